// File: rtl/crossing_arbiter.sv
// ---------------------------------------------------------------------------
// crossing_arbiter
//
// Round-robin arbiter for a road crossing. Three requesters (NS cars,
// pedestrians, EW cars) share the intersection and one external 4-bit
// countdown timer. Requests are latched, one requester is granted at a time,
// and each grant is walked through its timed phases by loading and enabling
// the shared timer. Everything runs on the slow (1 Hz) phase clock.
//
// Ports:
//   clk        phase clock
//   rstb       asynchronous active-low reset
//   req_ns     NS car present (level)
//   req_ew     EW car present (level)
//   req_ped    pedestrian button (level)
//   timer_out  current count of the shared countdown timer
//   timer_en   timer count enable
//   timer_load one-cycle timer load strobe
//   timer_init timer load value, meaningful while timer_load=1
//   grant      one-hot {ns, ped, ew}, 000 when nobody owns the crossing
//   phase      0=IDLE 1=GREEN 2=YELLOW 3=WALK 4=ALLRED
//   pending    latched requests {ns, ped, ew}
// ---------------------------------------------------------------------------
module crossing_arbiter #(
    parameter logic [3:0] GREEN_TIME  = 4'd5,
    parameter logic [3:0] YELLOW_TIME = 4'd2,
    parameter logic [3:0] WALK_TIME   = 4'd4,
    parameter logic [3:0] ALLRED_TIME = 4'd1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       req_ped,
    input  logic [3:0] timer_out,
    output logic       timer_en,
    output logic       timer_load,
    output logic [3:0] timer_init,
    output logic [2:0] grant,
    output logic [2:0] phase,
    output logic [2:0] pending
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        WALK   = 3'd3,
        ALLRED = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] pending_q, pending_d;
    logic [1:0] lastIdx_q, lastIdx_d;
    logic       armed_q, armed_d;
    logic       timerEn_q, timerEn_d;
    logic       timerLoad_q, timerLoad_d;
    logic [3:0] timerInit_q, timerInit_d;

    logic [2:0] reqVec;
    logic [2:0] clearVec;
    logic [2:0] winOneHot;
    logic [1:0] winIdx;
    logic       winValid;
    logic       expired;

    // Bit positions follow the {ns, ped, ew} packing: 2=NS, 1=PED, 0=EW.
    assign reqVec  = {req_ns, req_ped, req_ew};
    assign expired = armed_q && (timer_out == 4'd0);

    // Round-robin pick: the service order NS->PED->EW->NS walks the bit
    // index downwards cyclically, starting just after the last one served.
    always_comb begin
        winValid = |pending_q;
        winIdx   = 2'd0;
        case (lastIdx_q)
            2'd0: begin
                if (pending_q[2])      winIdx = 2'd2;
                else if (pending_q[1]) winIdx = 2'd1;
                else                   winIdx = 2'd0;
            end
            2'd1: begin
                if (pending_q[0])      winIdx = 2'd0;
                else if (pending_q[2]) winIdx = 2'd2;
                else                   winIdx = 2'd1;
            end
            default: begin
                if (pending_q[1])      winIdx = 2'd1;
                else if (pending_q[0]) winIdx = 2'd0;
                else                   winIdx = 2'd2;
            end
        endcase
        winOneHot = 3'b001 << winIdx;
    end

    // Phase sequencing. Every change into a timed phase fires one load
    // strobe; armed drops for that first cycle because the timer still
    // shows its old count until the load lands.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastIdx_d   = lastIdx_q;
        clearVec    = 3'b000;
        timerLoad_d = 1'b0;
        timerInit_d = timerInit_q;

        case (state_q)
            IDLE: begin
                grant_d = 3'b000;
                if (winValid) begin
                    state_d   = (winIdx == 2'd1) ? WALK : GREEN;
                    grant_d   = winOneHot;
                    lastIdx_d = winIdx;
                    clearVec  = winOneHot;
                end
            end
            GREEN: begin
                // A green with nobody else waiting simply parks at a zero
                // timer until a competing request shows up.
                if (expired && (pending_q != 3'b000)) begin
                    state_d = YELLOW;
                end
            end
            YELLOW, WALK: begin
                if (expired) begin
                    state_d = ALLRED;
                    grant_d = 3'b000;
                end
            end
            ALLRED: begin
                if (expired) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase

        if ((state_d != state_q) && (state_d != IDLE)) begin
            timerLoad_d = 1'b1;
            case (state_d)
                GREEN:   timerInit_d = GREEN_TIME;
                YELLOW:  timerInit_d = YELLOW_TIME;
                WALK:    timerInit_d = WALK_TIME;
                default: timerInit_d = ALLRED_TIME;
            endcase
        end

        armed_d   = (state_d == state_q) && (state_q != IDLE);
        timerEn_d = (state_d != IDLE);

        // Clear beats set, and the owner of the crossing cannot re-latch.
        pending_d = (pending_q | (reqVec & ~grant_q)) & ~clearVec;
    end

    // All outputs come straight from these registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            grant_q     <= 3'b000;
            pending_q   <= 3'b000;
            lastIdx_q   <= 2'd0;
            armed_q     <= 1'b0;
            timerEn_q   <= 1'b0;
            timerLoad_q <= 1'b0;
            timerInit_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            pending_q   <= pending_d;
            lastIdx_q   <= lastIdx_d;
            armed_q     <= armed_d;
            timerEn_q   <= timerEn_d;
            timerLoad_q <= timerLoad_d;
            timerInit_q <= timerInit_d;
        end
    end

    assign phase      = state_q;
    assign grant      = grant_q;
    assign pending    = pending_q;
    assign timer_en   = timerEn_q;
    assign timer_load = timerLoad_q;
    assign timer_init = timerInit_q;

endmodule

// File: tb/tb_crossing_arbiter.sv
// ---------------------------------------------------------------------------
// tb_crossing_arbiter
//
// Drives two arbiters from the same request stimulus: one with default
// timings and one with a zero-length yellow. Each owns a behavioural model
// of the shared countdown timer. A reference model tracks phase and
// cycles-spent-in-phase per instance and predicts every registered output.
// ---------------------------------------------------------------------------
module tb_crossing_arbiter;

    logic       clk = 1'b0;
    logic       rstb;
    logic       reqNs, reqEw, reqPed;
    logic [3:0] timer0 = 4'd0;
    logic [3:0] timer1 = 4'd0;

    logic       enV     [2];
    logic       loadV   [2];
    logic [3:0] initV   [2];
    logic [2:0] grantV  [2];
    logic [2:0] phaseV  [2];
    logic [2:0] pendingV[2];

    int errors = 0;
    int checks = 0;

    // Reference model state, one slot per instance.
    int         mPhase  [2];
    int         mAge    [2];
    int         mLast   [2];
    logic [2:0] mGrant  [2];
    logic [2:0] mPending[2];
    logic       mLoad   [2];
    logic       mEn     [2];
    logic [3:0] mInit   [2];
    logic       prevLoad[2];

    // Slow clock stand-in for the 1 Hz phase clock.
    always #5 clk = ~clk;

    crossing_arbiter dutA (
        .clk(clk), .rstb(rstb),
        .req_ns(reqNs), .req_ew(reqEw), .req_ped(reqPed),
        .timer_out(timer0),
        .timer_en(enV[0]), .timer_load(loadV[0]), .timer_init(initV[0]),
        .grant(grantV[0]), .phase(phaseV[0]), .pending(pendingV[0])
    );

    crossing_arbiter #(.YELLOW_TIME(4'd0)) dutB (
        .clk(clk), .rstb(rstb),
        .req_ns(reqNs), .req_ew(reqEw), .req_ped(reqPed),
        .timer_out(timer1),
        .timer_en(enV[1]), .timer_load(loadV[1]), .timer_init(initV[1]),
        .grant(grantV[1]), .phase(phaseV[1]), .pending(pendingV[1])
    );

    // Shared countdown timers: load wins, otherwise count down to zero.
    always @(posedge clk) begin
        if (loadV[0])                      timer0 <= initV[0];
        else if (enV[0] && timer0 != 4'd0) timer0 <= timer0 - 4'd1;
    end

    always @(posedge clk) begin
        if (loadV[1])                      timer1 <= initV[1];
        else if (enV[1] && timer1 != 4'd0) timer1 <= timer1 - 4'd1;
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
        end
    endtask

    // Phase durations; instance 1 has the zero-length yellow.
    function automatic int durOf(input int ph, input int c);
        case (ph)
            1:       return 5;
            2:       return (c == 0) ? 2 : 0;
            3:       return 4;
            4:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic resetModel(input int c);
        mPhase[c]   = 0;
        mAge[c]     = 0;
        mLast[c]    = 2;
        mGrant[c]   = 3'b000;
        mPending[c] = 3'b000;
        mLoad[c]    = 1'b0;
        mEn[c]      = 1'b0;
        mInit[c]    = 4'd0;
    endtask

    // Service order index: 0=NS, 1=PED, 2=EW; bit in {ns,ped,ew} = 2-index.
    // A timed phase of duration D lasts D+2 cycles, so it is done when the
    // zero-based age reaches D+1.
    task automatic modelStep(input int c, input logic [2:0] r);
        int         nPhase;
        int         sel;
        int         o;
        logic [2:0] nGrant;
        logic [2:0] clr;
        logic       done;
        logic       found;
        nPhase = mPhase[c];
        nGrant = mGrant[c];
        clr    = 3'b000;
        found  = 1'b0;
        sel    = 0;
        done   = (mPhase[c] != 0) && (mAge[c] >= durOf(mPhase[c], c) + 1);
        case (mPhase[c])
            0: begin
                for (int k = 1; k <= 3; k++) begin
                    o = (mLast[c] + k) % 3;
                    if (!found && mPending[c][2 - o]) begin
                        found = 1'b1;
                        sel   = o;
                    end
                end
                if (found) begin
                    nPhase   = (sel == 1) ? 3 : 1;
                    nGrant   = 3'b001 << (2 - sel);
                    clr      = nGrant;
                    mLast[c] = sel;
                end
            end
            1: if (done && mPending[c] != 3'b000) nPhase = 2;
            2, 3: if (done) begin
                nPhase = 4;
                nGrant = 3'b000;
            end
            4: if (done) nPhase = 0;
            default: nPhase = 0;
        endcase
        mPending[c] = (mPending[c] | (r & ~mGrant[c])) & ~clr;
        if (nPhase != mPhase[c]) begin
            mAge[c]  = 0;
            mLoad[c] = (nPhase != 0);
            if (nPhase != 0) mInit[c] = 4'(durOf(nPhase, c));
        end else begin
            mAge[c]++;
            mLoad[c] = 1'b0;
        end
        mEn[c]    = (nPhase != 0);
        mPhase[c] = nPhase;
        mGrant[c] = nGrant;
    endtask

    task automatic compareAll();
        for (int c = 0; c < 2; c++) begin
            checkOutput($sformatf("phase%0d", c),   phaseV[c],   mPhase[c]);
            checkOutput($sformatf("grant%0d", c),   grantV[c],   mGrant[c]);
            checkOutput($sformatf("pending%0d", c), pendingV[c], mPending[c]);
            checkOutput($sformatf("load%0d", c),    loadV[c],    mLoad[c]);
            checkOutput($sformatf("en%0d", c),      enV[c],      mEn[c]);
            if (mLoad[c] || !rstb)
                checkOutput($sformatf("init%0d", c), initV[c], mInit[c]);
            checkOutput($sformatf("oneGrant%0d", c), $countones(grantV[c]) <= 1, 1);
            checkOutput($sformatf("grantInPhase%0d", c),
                        (grantV[c] != 3'b000) && !(phaseV[c] inside {3'd1, 3'd2, 3'd3}), 0);
            checkOutput($sformatf("loadTwice%0d", c), loadV[c] && prevLoad[c], 0);
            prevLoad[c] = loadV[c];
        end
    endtask

    // One clock of stimulus: drive away from the edge, advance the model
    // on the edge, compare on the falling edge.
    task automatic applyStimulus(input logic ns, input logic ped, input logic ew);
        reqNs  = ns;
        reqPed = ped;
        reqEw  = ew;
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (!rstb) resetModel(c);
            else       modelStep(c, {ns, ped, ew});
        end
        @(negedge clk);
        compareAll();
    endtask

    task automatic checkResetValues(input string tag);
        for (int c = 0; c < 2; c++) begin
            checkOutput($sformatf("%sPhase%0d", tag, c),   phaseV[c],   0);
            checkOutput($sformatf("%sGrant%0d", tag, c),   grantV[c],   0);
            checkOutput($sformatf("%sPending%0d", tag, c), pendingV[c], 0);
            checkOutput($sformatf("%sLoad%0d", tag, c),    loadV[c],    0);
            checkOutput($sformatf("%sEn%0d", tag, c),      enV[c],      0);
            checkOutput($sformatf("%sInit%0d", tag, c),    initV[c],    0);
        end
    endtask

    initial begin
        int         yCntA, yCntB, aCnt, nGrants, walkLen, afterWalk, guard;
        logic [2:0] prevGrant, prevPhase;
        logic [2:0] gSeq [4];
        logic [2:0] expSeq [4];

        expSeq[0] = 3'b100; expSeq[1] = 3'b010; expSeq[2] = 3'b001; expSeq[3] = 3'b100;
        rstb = 1'b0; reqNs = 1'b0; reqEw = 1'b0; reqPed = 1'b0;
        for (int c = 0; c < 2; c++) begin
            resetModel(c);
            prevLoad[c] = 1'b0;
        end
        @(negedge clk);
        checkResetValues("reset");
        applyStimulus(0, 0, 0);
        rstb = 1'b1;

        // Single NS request: latch, then grant with a 5-count green that
        // holds indefinitely while nobody else waits.
        applyStimulus(1, 0, 0);
        checkOutput("t1Pending", pendingV[0], 3'b100);
        applyStimulus(0, 0, 0);
        checkOutput("t1Grant", grantV[0], 3'b100);
        checkOutput("t1Load",  loadV[0],  1);
        checkOutput("t1Init",  initV[0],  5);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0);
        checkOutput("t1Hold", phaseV[0], 1);

        // EW pulse ends the held green; measure yellow and all-red lengths.
        applyStimulus(0, 0, 1);
        yCntA = 0; yCntB = 0; aCnt = 0; guard = 0;
        while (grantV[0] != 3'b001 && guard < 40) begin
            applyStimulus(0, 0, 0);
            if (phaseV[0] == 3'd2) yCntA++;
            if (phaseV[0] == 3'd4) aCnt++;
            if (phaseV[1] == 3'd2) yCntB++;
            guard++;
        end
        checkOutput("t2Grant",     grantV[0], 3'b001);
        checkOutput("t2YellowLen", yCntA, 4);
        checkOutput("t2AllredLen", aCnt,  3);
        checkOutput("t6YellowZeroLen", yCntB, 2);

        // All three held from reset: strict NS, PED, EW, NS rotation.
        rstb = 1'b0;
        applyStimulus(1, 1, 1);
        rstb = 1'b1;
        nGrants = 0; walkLen = 0; afterWalk = -1; guard = 0;
        prevGrant = 3'b000; prevPhase = 3'd0;
        while (nGrants < 4 && guard < 120) begin
            applyStimulus(1, 1, 1);
            if (grantV[0] != 3'b000 && prevGrant == 3'b000) begin
                gSeq[nGrants] = grantV[0];
                nGrants++;
            end
            if (grantV[0] == 3'b100) checkOutput("t4NsNoRelatch", pendingV[0][2], 0);
            if (phaseV[0] == 3'd3 && afterWalk < 0) walkLen++;
            if (prevPhase == 3'd3 && phaseV[0] != 3'd3 && afterWalk < 0) afterWalk = phaseV[0];
            prevGrant = grantV[0];
            prevPhase = phaseV[0];
            guard++;
        end
        checkOutput("t3GrantCount", nGrants, 4);
        for (int i = 0; i < 4; i++)
            if (i < nGrants) checkOutput($sformatf("t3Order%0d", i), gSeq[i], expSeq[i]);
        checkOutput("t3WalkLen",   walkLen,   6);
        checkOutput("t3AfterWalk", afterWalk, 4);

        // Reset pulse in the middle of a walk phase.
        guard = 0;
        while (phaseV[0] != 3'd3 && guard < 60) begin
            applyStimulus(1, 1, 1);
            guard++;
        end
        applyStimulus(1, 1, 1);
        checkOutput("t5InWalk", phaseV[0], 3);
        rstb = 1'b0;
        #1;
        checkResetValues("asyncReset");
        for (int c = 0; c < 2; c++) resetModel(c);
        @(negedge clk);
        applyStimulus(1, 1, 1);
        rstb = 1'b1;
        guard = 0;
        while (grantV[0] == 3'b000 && guard < 10) begin
            applyStimulus(1, 1, 1);
            guard++;
        end
        checkOutput("t5NsFirst", grantV[0], 3'b100);

        // Randomized traffic, every cycle checked against the model.
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 3) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
